// File: rtl/instr_stream_loader.sv
// Boot loader between a byte stream and the CPU memories: assembles big-endian words,
// writes them while holding the CPU in reset, then releases it.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no session, CPU held in reset
// CNT_HI  | waiting for word-count high byte
// CNT_LO  | waiting for word-count low byte
// MODE    | waiting for target select (0x00 instr, 0x01 data)
// COLLECT | shifting payload bytes into the current word
// WRITE   | strobe asserted for WRITE_HOLD cycles, address/data stable
// RUN     | program loaded, CPU released
// ERR     | malformed header, sticky until reset
module instr_stream_loader #(
    parameter int ADDR_W     = 10,
    parameter int WRITE_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] address,
    output logic              write_instruction,
    output logic              write_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_MODE,
        S_COLLECT,
        S_WRITE,
        S_RUN,
        S_ERR
    } state_t;

    localparam int HOLD_W = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WRITE_HOLD - 1);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t              state;
    logic [15:0]         word_count;
    logic [ADDR_W-1:0]   last_addr;
    logic                mode_data;
    logic [1:0]          byte_cnt;
    logic [23:0]         word_sr;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                xfer;

    assign byte_ready = (state == S_CNT_HI) || (state == S_CNT_LO) ||
                        (state == S_MODE)   || (state == S_COLLECT);
    assign busy       = byte_ready || (state == S_WRITE);
    assign cpu_rst    = (state != S_RUN);
    assign xfer       = byte_valid && byte_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= S_IDLE;
            word_count        <= '0;
            last_addr         <= '0;
            mode_data         <= 1'b0;
            byte_cnt          <= '0;
            word_sr           <= '0;
            hold_cnt          <= '0;
            inst_data         <= '0;
            address           <= '0;
            write_instruction <= 1'b0;
            write_data        <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) state <= S_CNT_HI;
                end
                S_CNT_HI: begin
                    if (xfer) begin
                        word_count[15:8] <= byte_in;
                        state            <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (xfer) begin
                        word_count[7:0] <= byte_in;
                        state           <= S_MODE;
                    end
                end
                S_MODE: begin
                    if (xfer) begin
                        if (byte_in > 8'h01 || {1'b0, word_count} > MAX_WORDS) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end else if (word_count == 16'd0) begin
                            done  <= 1'b1;
                            state <= S_RUN;
                        end else begin
                            mode_data <= byte_in[0];
                            address   <= '0;
                            byte_cnt  <= '0;
                            // count is bounded above, so N-1 always fits the address width
                            last_addr <= ADDR_W'(word_count - 16'd1);
                            state     <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            inst_data         <= {word_sr, byte_in};
                            hold_cnt          <= HOLD_LAST;
                            write_instruction <= !mode_data;
                            write_data        <= mode_data;
                            state             <= S_WRITE;
                        end else begin
                            word_sr <= {word_sr[15:0], byte_in};
                        end
                    end
                end
                S_WRITE: begin
                    if (hold_cnt == '0) begin
                        write_instruction <= 1'b0;
                        write_data        <= 1'b0;
                        if (address == last_addr) begin
                            done  <= 1'b1;
                            state <= S_RUN;
                        end else begin
                            address <= address + 1'b1;
                            state   <= S_COLLECT;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (start) state <= S_CNT_HI;
                end
                S_ERR: begin
                    err <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Randomized bench for instr_stream_loader: a stream-level model predicts every memory
// write, the CPU release and the header errors; a monitor records what the DUT did.
module tb_instr_stream_loader;

    localparam int ADDR_W     = 10;
    localparam int WRITE_HOLD = 2;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        int          addr;
        logic [31:0] data;
        logic        is_data;
        int          len;
        int          rise;
    } wr_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] address;
    logic              write_instruction;
    logic              write_data;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    instr_stream_loader #(.ADDR_W(ADDR_W), .WRITE_HOLD(WRITE_HOLD)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .byte_in           (byte_in),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .inst_data         (inst_data),
        .address           (address),
        .write_instruction (write_instruction),
        .write_data        (write_data),
        .cpu_rst           (cpu_rst),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    bit  spam_start = 0;

    wr_t obs_q[$];
    int  xq[$];
    wr_t cur;
    int  run_len     = 0;
    int  both_seen   = 0;
    int  unstable    = 0;
    int  done_total  = 0;
    int  done_long   = 0;
    int  rel_cnt     = 0;
    int  rel_cyc     = 0;
    int  last_hi_cyc = 0;
    bit  done_prev   = 0;
    bit  rst_prev    = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // observes strobe runs, done pulses and CPU release moments
    initial forever begin
        @(negedge clk);
        if (write_instruction && write_data) both_seen++;
        if (write_instruction || write_data) begin
            if (run_len == 0) begin
                cur.addr    = int'(address);
                cur.data    = inst_data;
                cur.is_data = write_data;
                cur.rise    = cyc;
            end else if (int'(address) != cur.addr || inst_data != cur.data) begin
                unstable++;
            end
            run_len++;
            last_hi_cyc = cyc;
        end else if (run_len > 0) begin
            cur.len = run_len;
            obs_q.push_back(cur);
            run_len = 0;
        end
        if (done) done_total++;
        if (done && done_prev) done_long++;
        done_prev = done;
        if (!cpu_rst && rst_prev) begin
            rel_cnt++;
            rel_cyc = cyc;
        end
        rst_prev = cpu_rst;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int ng;
        bit acc;
        bit got;
        ng  = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        got = 0;
        byte_valid = 0;
        repeat (ng) begin
            start = spam_start && (write_instruction || write_data);
            @(posedge clk);
            #1;
        end
        byte_in    = b;
        byte_valid = 1;
        for (int k = 0; k < 400 && !got; k++) begin
            acc   = byte_ready;
            start = spam_start && (write_instruction || write_data);
            @(posedge clk);
            #1;
            got = acc;
        end
        byte_valid = 0;
        start      = 0;
        if (!got) check_val("byte_accept_timeout", 0, 1);
    endtask

    task automatic run_session(input byte_q_t b, input int gap, input bit spam);
        int          base;
        int          d0;
        int          r0;
        int          n;
        int          nexp;
        int          nobs;
        int          k;
        logic [7:0]  mode;
        bit          exp_err;
        logic [31:0] w;
        base = obs_q.size();
        d0   = done_total;
        r0   = rel_cnt;
        xq.delete();
        n       = int'({b[0], b[1]});
        mode    = b[2];
        exp_err = (mode > 8'h01) || (n > (1 << ADDR_W));
        nexp    = exp_err ? 0 : n;

        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        check_val("start_busy", busy, 1);
        check_val("start_cpu_rst", cpu_rst, 1);

        spam_start = spam;
        for (int i = 0; i < b.size(); i++) begin
            if (exp_err && i > 2) break;
            send_byte(b[i], gap);
            if (i >= 3 && ((i - 3) % 4) == 3) xq.push_back(cyc);
        end
        k = 0;
        while (k < 400 && !err && !(!cpu_rst && !busy)) begin
            start = spam && (write_instruction || write_data);
            @(posedge clk);
            #1;
            k++;
        end
        start      = 0;
        spam_start = 0;
        check_val("session_end_timeout", k < 400, 1);
        repeat (3) @(posedge clk);
        #1;

        nobs = obs_q.size() - base;
        check_val("write_count", nobs, nexp);
        for (int i = 0; i < nexp && i < nobs && i < xq.size(); i++) begin
            w = {b[3 + 4*i], b[4 + 4*i], b[5 + 4*i], b[6 + 4*i]};
            check_val("write_addr", obs_q[base + i].addr, i);
            check_val("write_word", obs_q[base + i].data, w);
            check_val("write_target", obs_q[base + i].is_data, mode[0]);
            check_val("strobe_len", obs_q[base + i].len, WRITE_HOLD);
            check_val("strobe_latency", obs_q[base + i].rise, xq[i]);
        end
        check_val("err_flag", err, exp_err);
        check_val("cpu_rst_end", cpu_rst, exp_err);
        check_val("done_pulses", done_total - d0, exp_err ? 0 : 1);
        check_val("cpu_release_count", rel_cnt - r0, exp_err ? 0 : 1);
        if (nexp > 0) check_val("release_latency", rel_cyc, last_hi_cyc + 1);
    endtask

    byte_q_t v;
    int      base0;
    int      nr;
    logic [15:0] n16;

    initial begin
        rst        = 0;
        start      = 0;
        byte_in    = 8'h00;
        byte_valid = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_val("rst_cpu_rst", cpu_rst, 1);
        check_val("rst_byte_ready", byte_ready, 0);
        check_val("rst_write_instruction", write_instruction, 0);
        check_val("rst_write_data", write_data, 0);
        check_val("rst_err", err, 0);
        check_val("rst_done", done, 0);
        check_val("rst_busy", busy, 0);
        rst = 1;
        @(posedge clk);
        #1;

        v = {8'h00, 8'h02, 8'h00, 8'h04, 8'h22, 8'h00, 8'h01, 8'h04, 8'h20, 8'h00, 8'h0A};
        run_session(v, -1, 0);

        // started from RUN: exercises the reload path as well
        v = {8'h00, 8'h01, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_session(v, 3, 0);

        v = {8'h00, 8'h00, 8'h00};
        run_session(v, 0, 0);

        v = {8'h00, 8'h02, 8'h00, 8'h04, 8'h22, 8'h00, 8'h01, 8'h04, 8'h20, 8'h00, 8'h0A};
        run_session(v, 0, 1);

        v = {8'h00, 8'h01, 8'h02};
        run_session(v, 0, 0);
        check_val("err_byte_ready", byte_ready, 0);
        check_val("err_busy", busy, 0);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("err_sticky_after_start", err, 1);
        check_val("err_start_ignored", busy, 0);
        do_reset(1);
        check_val("err_cleared_by_rst", err, 0);

        v = {8'h04, 8'h01, 8'h00};
        run_session(v, 0, 0);
        do_reset(1);
        check_val("err_cleared_by_rst2", err, 0);

        base0 = obs_q.size();
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        v = {8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
        foreach (v[i]) send_byte(v[i], 0);
        do_reset(1);
        check_val("mid_rst_byte_ready", byte_ready, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_cpu_rst", cpu_rst, 1);
        repeat (2) @(posedge clk);
        #1;
        check_val("mid_rst_no_write", obs_q.size() - base0, 0);

        v = {8'h00, 8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        run_session(v, -1, 0);

        for (int s = 0; s < 8; s++) begin
            nr  = (s == 5) ? 0 : int'($urandom_range(1, 5));
            n16 = 16'(nr);
            v.delete();
            v.push_back(n16[15:8]);
            v.push_back(n16[7:0]);
            v.push_back(8'($urandom_range(0, 1)));
            for (int i = 0; i < 4 * nr; i++) v.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) do_reset(1);
            run_session(v, -1, $urandom_range(0, 1) == 1);
        end

        // largest legal program: fills the memory without address wrap
        v.delete();
        v.push_back(8'h04);
        v.push_back(8'h00);
        v.push_back(8'h01);
        for (int i = 0; i < 4 * (1 << ADDR_W); i++) v.push_back(8'($urandom_range(0, 255)));
        run_session(v, 0, 0);

        check_val("strobes_exclusive", both_seen, 0);
        check_val("write_stable", unstable, 0);
        check_val("done_single_cycle", done_long, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
